imem_responder: RTL
===================

// Module: imem_responder
// PURPOSE
//  Responder side of the instruction-fetch read interface: serves 32-bit word fetches from a
//  1R1W synchronous instruction RAM over a valid/ready request/response handshake.
//  Adds programmable wait states and holds the response while the fetch stage stalls.
//  Includes a sequential load port so a boot loader/testbench can write program words.
//  Sits between the fetch stage (initiator) and the instruction storage.
// PARAMETERS
//  DEPTH_LOG2   9      log2 of RAM depth in 32-bit words (512 words = byte addr[10:2])
//  WAIT_STATES  0      extra cycles between request accept and response (0..15)
// PORTS
//  clk         in   1   clock, all state on rising edge
//  reset       in   1   synchronous, active-high
//  req_valid   in   1   fetch request present
//  req_addr    in   32  byte address of requested instruction word
//  req_ready   out  1   request accepted when req_valid && req_ready
//  rsp_valid   out  1   response present
//  rsp_data    out  32  instruction word
//  rsp_addr    out  32  byte address the response belongs to
//  rsp_err     out  1   address (or parity) error for this response
//  rsp_ready   in   1   consumer accepts; low = fetch stall
//  load_valid  in   1   program-load write request
//  load_addr   in   DEPTH_LOG2  word index to write
//  load_data   in   32  word to write
//  load_ready  out  1   load accepted when load_valid && load_ready (always 1 after reset)
// BEHAVIOUR
//  Reset: req_ready=0, rsp_valid=0, rsp_data=0, rsp_addr=0, rsp_err=0, load_ready=0; state=IDLE,
//   wait counter=0. RAM contents are not reset. Reset mid-transaction drops in-flight request.
//  FSM: IDLE -> (accept, WAIT_STATES>0) WAIT -> (counter==WAIT_STATES) RESP;
//   IDLE -> (accept, WAIT_STATES==0) RESP. RESP -> (rsp_ready, no new accept) IDLE;
//   RESP -> (rsp_ready && new accept) WAIT or RESP (back-to-back).
//  req_ready = !load_valid && (state==IDLE || (state==RESP && rsp_ready)).
//  Latency: accept in cycle N -> rsp_valid in cycle N+1+WAIT_STATES; WAIT_STATES==0 gives
//   one response per cycle sustained while rsp_ready stays high.
//  Stall: while rsp_valid && !rsp_ready, rsp_data/rsp_addr/rsp_err are held unchanged
//   (captured in a hold register, not re-read from RAM); no new request is accepted.
//  Load priority: load_valid in the same cycle as req_valid wins; req_ready=0 that cycle.
//  Write/read collision: a request accepted before a write to the same word returns the
//   old word (read-before-write); a request accepted after the write returns the new word.
//  Address check: req_addr[1:0]!=0 or any req_addr[31:DEPTH_LOG2+2]!=0 -> rsp_err=1,
//   rsp_data=0; RAM index is req_addr[DEPTH_LOG2+1:2].
//  rsp_addr = req_addr of the accepted request, unmodified.
// CONFIGURATION
//  IMEM_PARITY_EN defined: RAM stores 33 bits/word (even parity over load_data computed
//   on write). Extra input err_inject (1 bit): when high with a load, the stored parity bit
//   is inverted. Parity mismatch on read -> rsp_err=1. rsp_data = the stored word, unzeroed.
//  IMEM_PARITY_EN undefined: 32-bit RAM, no err_inject port, rsp_err from address check only.
// STRUCTURE
//  imem_pkg: state enum {IDLE,WAIT,RESP}; constant RV_NOP=32'h0000_0013; packed struct
//   imem_rsp_t {data,addr,err}; function word_parity().
//  Sub-module imem_array: 1R1W synchronous RAM, write port has priority; read returns the
//   old data on a same-cycle collision.
//  Top: FSM, wait counter ($clog2(WAIT_STATES+1) bits, minimum 1), hold register, address check.
// TESTING
//  1 Reset held 3 cycles -> all outputs 0; req_ready=1 and load_ready=1 on the first cycle
//    after release.
//  2 Load words 0..3 = 32'hA0..A3; WAIT_STATES=0; request addrs 0,4,8,12 back-to-back with
//    rsp_ready=1 -> rsp_data A0..A3 on 4 consecutive cycles, each 1 cycle after accept.
//  3 WAIT_STATES=3; request addr 4 -> rsp_valid exactly 4 cycles after accept, data A1.
//  4 Respond with rsp_ready=0 for 5 cycles -> rsp_data/rsp_addr stable, req_ready=0.
//    rsp_ready=1 -> next request accepted the same cycle.
//  5 load_valid and req_valid in the same cycle to word 2 (new value 32'hBEEF) -> req_ready=0.
//    The retried request returns 32'hBEEF. Request addr 6 -> rsp_err=1, rsp_data=0.
//    Request addr 32'h800 (DEPTH_LOG2=9) -> rsp_err=1, rsp_data=0.
//  6 IMEM_PARITY_EN only: load word 5 with err_inject=1; fetch addr 20 -> rsp_err=1 and
//    rsp_data=stored word. Reload without inject -> rsp_err=0.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types for the instruction-fetch responder: FSM states, response record, parity helper.
package imem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam logic [31:0] RV_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] addr;
        logic        err;
    } imem_rsp_t;

    // Even parity: the stored bit makes the 33-bit total an even number of ones.
    function automatic logic word_parity(input logic [31:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/imem_responder_if.sv
// Fetch request/response handshake between the fetch stage (master) and the instruction responder (slave).
interface imem_responder_if;

    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic [31:0] rsp_addr;
    logic        rsp_err;
    logic        rsp_ready;

    modport master (
        output req_valid, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_addr, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_addr, rsp_err
    );

endinterface

// File: rtl/imem_array.sv
// 1R1W synchronous instruction RAM; a read colliding with a write to the same word returns the old word.
module imem_array #(
    parameter int DEPTH_LOG2 = 9,
    parameter int WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);

    // NOTE: storage has no reset so it maps onto a RAM macro; contents come from the load port.
    logic [WIDTH-1:0] mem [0:(1 << DEPTH_LOG2)-1];

    // NOTE: both updates are non-blocking, so a same-edge read samples the word before the write lands.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/imem_responder.sv
// Instruction-fetch responder: wait states, stall hold register, address check, program-load port.
// Optional IMEM_PARITY_EN: 33-bit words with even parity, err_inject port, parity errors on rsp_err.
module imem_responder
    import imem_pkg::*;
#(
    parameter int DEPTH_LOG2  = 9,
    parameter int WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    imem_responder_if.slave       bus,
    input  logic                  load_valid,
    input  logic [DEPTH_LOG2-1:0] load_addr,
    input  logic [31:0]           load_data,
    output logic                  load_ready
`ifdef IMEM_PARITY_EN
    ,
    input  logic                  err_inject
`endif
);

    localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_STATES);
`ifdef IMEM_PARITY_EN
    localparam int RAM_W = 33;
`else
    localparam int RAM_W = 32;
`endif

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic [31:0]      addr_q;
    logic             addr_err_q;
    logic             first_q;
    logic             rsp_valid_q;
    imem_rsp_t        hold_q;
    imem_rsp_t        live;
    imem_rsp_t        rsp_cur;
    logic [RAM_W-1:0] ram_wdata;
    logic [RAM_W-1:0] ram_rdata;
    logic             accept;
    logic             addr_err;
    logic             load_we;

    assign load_we       = load_valid && load_ready;
    assign bus.req_ready = load_ready && !load_valid &&
                           (state == IDLE || (state == RESP && bus.rsp_ready));
    assign accept        = bus.req_valid && bus.req_ready;
    assign addr_err      = (bus.req_addr[1:0] != 2'b00) ||
                           (bus.req_addr[31:DEPTH_LOG2+2] != '0);

`ifdef IMEM_PARITY_EN
    assign ram_wdata = {word_parity(load_data) ^ err_inject, load_data};
`else
    assign ram_wdata = load_data;
`endif

    // The RAM is read at accept time, so a load arriving during the wait states cannot leak in.
    imem_array #(
        .DEPTH_LOG2(DEPTH_LOG2),
        .WIDTH     (RAM_W)
    ) u_array (
        .clk  (clk),
        .we   (load_we),
        .waddr(load_addr),
        .wdata(ram_wdata),
        .re   (accept),
        .raddr(bus.req_addr[DEPTH_LOG2+1:2]),
        .rdata(ram_rdata)
    );

    always_comb begin
        live.addr = addr_q;
        live.data = addr_err_q ? 32'h0 : ram_rdata[31:0];
`ifdef IMEM_PARITY_EN
        live.err  = addr_err_q || (word_parity(ram_rdata[31:0]) != ram_rdata[32]);
`else
        live.err  = addr_err_q;
`endif
    end

    // First response cycle comes straight from the RAM; afterwards the hold register owns it.
    assign rsp_cur       = first_q ? live : hold_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_cur.data;
    assign bus.rsp_addr  = rsp_cur.addr;
    assign bus.rsp_err   = rsp_cur.err;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            addr_q      <= '0;
            addr_err_q  <= 1'b0;
            first_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            hold_q      <= '0;
            load_ready  <= 1'b0;
        end else begin
            load_ready <= 1'b1;
            first_q    <= 1'b0;
            if (first_q) begin
                hold_q <= live;
            end
            if (accept) begin
                addr_q     <= bus.req_addr;
                addr_err_q <= addr_err;
            end
            case (state)
                IDLE, RESP: begin
                    if (accept) begin
                        if (WAIT_STATES == 0) begin
                            state       <= RESP;
                            rsp_valid_q <= 1'b1;
                            first_q     <= 1'b1;
                        end else begin
                            state       <= WAIT;
                            wait_cnt    <= CNT_W'(1);
                            rsp_valid_q <= 1'b0;
                        end
                    end else if (state == RESP && bus.rsp_ready) begin
                        state       <= IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                WAIT: begin
                    if (wait_cnt == CNT_LAST) begin
                        state       <= RESP;
                        wait_cnt    <= '0;
                        rsp_valid_q <= 1'b1;
                        first_q     <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
